letc_core_scoreboard: RTL and testbench

Register scoreboard and issue controller for the LETC core. It sits between decode and execute. It tracks which integer registers have a write in flight, and it stalls issue of any instruction whose sources or destination collide with a pending write. It classifies operand usage directly from the 5-bit RISC-V major opcode (`opcode_e` in `letc_pkg`), clears entries on writeback, supports pipeline flush, and keeps a saturating stall counter for performance monitoring.

---
 rtl/letc_core_scoreboard.sv | 138 +++++++++++++
 tb/tb_letc_core_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/letc_core_scoreboard.sv
// LETC register scoreboard and issue controller between decode and execute.
// Option: LETC_SCOREBOARD_WB_BYPASS_EN lets same-cycle writeback unblock issue.
package letc_pkg;
  typedef logic [4:0] reg_index_t;

  typedef enum logic [4:0] {
    LOAD     = 5'b00000,
    MISC_MEM = 5'b00011,
    OP_IMM   = 5'b00100,
    AUIPC    = 5'b00101,
    STORE    = 5'b01000,
    AMO      = 5'b01011,
    OP       = 5'b01100,
    LUI      = 5'b01101,
    BRANCH   = 5'b11000,
    JALR     = 5'b11001,
    JAL      = 5'b11011,
    SYSTEM   = 5'b11100
  } opcode_e;
endpackage

module letc_core_scoreboard
  import letc_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_issue_valid,
  output logic                   o_issue_ready,
  input  opcode_e                i_opcode,
  input  reg_index_t             i_rd,
  input  reg_index_t             i_rs1,
  input  reg_index_t             i_rs2,
  input  logic                   i_wb_valid,
  input  reg_index_t             i_wb_rd,
  output logic [31:0]            o_busy,
  output logic                   o_empty,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] hz_busy;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [STALL_CNT_W-1:0] stall_q;

  logic use_rs1;
  logic use_rs2;
  logic use_rd;
  logic is_sys;
  logic raw;
  logic waw;
  logic fire;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    is_sys  = 1'b0;
    unique case (i_opcode)
      LUI, AUIPC, JAL: begin
        use_rd = 1'b1;
      end
      JALR, LOAD, OP_IMM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP, AMO: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      STORE, BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      SYSTEM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        is_sys  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign clr_mask = (i_wb_valid && i_wb_rd != '0)
                  ? (32'(1) << i_wb_rd) : '0;

`ifdef LETC_SCOREBOARD_WB_BYPASS_EN
  assign hz_busy = busy_q & ~clr_mask;
`else
  assign hz_busy = busy_q;
`endif

  // busy_q[0] is never set, so x0 drops out of the hazard check for free
  assign raw = (use_rs1 && hz_busy[i_rs1])
            || (use_rs2 && hz_busy[i_rs2]);
  assign waw = use_rd && hz_busy[i_rd];

  assign o_issue_ready = !i_flush && !raw && !waw
                      && !(is_sys && !o_empty);
  assign fire = i_issue_valid && o_issue_ready;

  assign set_mask = (fire && use_rd && i_rd != '0)
                  ? (32'(1) << i_rd) : '0;

  // set is OR-ed after clear so a same-index collision stays busy
  assign busy_d = i_flush ? '0 : ((busy_q & ~clr_mask) | set_mask);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (i_issue_valid && !o_issue_ready && !i_flush
          && stall_q != '1) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign o_busy        = busy_q;
  assign o_empty       = (busy_q == '0);
  assign o_stall_count = stall_q;

`ifndef SYNTHESIS
  wb_to_busy_reg: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    (i_wb_valid && i_wb_rd != '0 && !i_flush) |-> busy_q[i_wb_rd]
  );
`endif

endmodule

// File: tb/tb_letc_core_scoreboard.sv
// Self-checking bench for letc_core_scoreboard: directed scenarios
// plus randomized traffic against a register-set reference model.
module tb_letc_core_scoreboard;
  import letc_pkg::*;

  localparam int W = 4;
`ifdef LETC_SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic iv = 1'b0;
  logic wbv = 1'b0;
  opcode_e op = MISC_MEM;
  reg_index_t rd = '0;
  reg_index_t rs1 = '0;
  reg_index_t rs2 = '0;
  reg_index_t wbrd = '0;
  logic ready;
  logic [31:0] busy;
  logic empty;
  logic [W-1:0] cnt;

  int n_chk = 0;
  int n_fail = 0;
  bit [31:0] m_busy;
  int m_cnt;

  opcode_e ops [12] = '{LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, AMO,
                        OP, LUI, BRANCH, JALR, JAL, SYSTEM};

  always #5 clk = ~clk;

  letc_core_scoreboard #(.STALL_CNT_W(W)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_flush(flush),
    .i_issue_valid(iv),
    .o_issue_ready(ready),
    .i_opcode(op),
    .i_rd(rd),
    .i_rs1(rs1),
    .i_rs2(rs2),
    .i_wb_valid(wbv),
    .i_wb_rd(wbrd),
    .o_busy(busy),
    .o_empty(empty),
    .o_stall_count(cnt)
  );

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // {serializing, writes rd, reads rs2, reads rs1}
  function automatic bit [3:0] uses(input opcode_e o);
    case (o)
      LUI, AUIPC, JAL:    return 4'b0100;
      JALR, LOAD, OP_IMM: return 4'b0101;
      OP, AMO:            return 4'b0111;
      STORE, BRANCH:      return 4'b0011;
      SYSTEM:             return 4'b1101;
      default:            return 4'b0000;
    endcase
  endfunction

  function automatic bit pending(input reg_index_t r);
    if (r == 0) return 1'b0;
    if (BYP && wbv && wbrd == r) return 1'b0;
    return m_busy[r];
  endfunction

  function automatic bit m_ready();
    bit [3:0] u = uses(op);
    bit hz = (u[0] && pending(rs1)) || (u[1] && pending(rs2))
          || (u[2] && pending(rd));
    return !flush && !hz && !(u[3] && m_busy != 0);
  endfunction

  function automatic bit [31:0] next_busy();
    bit [31:0] b = m_busy;
    if (flush) return '0;
    if (wbv && wbrd != 0) b[wbrd] = 1'b0;
    if (iv && m_ready() && uses(op)[2] && rd != 0) b[rd] = 1'b1;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= '0;
      m_cnt  <= 0;
    end else begin
      m_busy <= next_busy();
      if (iv && !m_ready() && !flush && m_cnt < (1 << W) - 1)
        m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    chk("ready", 64'(ready), 64'(m_ready()));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("empty", 64'(empty), 64'(m_busy == 0));
    chk("stall_count", 64'(cnt), 64'(m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iv = 0; flush = 0; wbv = 0; op = MISC_MEM;
    rd = 0; rs1 = 0; rs2 = 0; wbrd = 0;
  endtask

  task automatic drive(input opcode_e o, input int d, input int a,
                       input int b);
    iv = 1; op = o;
    rd = reg_index_t'(d); rs1 = reg_index_t'(a); rs2 = reg_index_t'(b);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n = 0;
    idle();
    #3;
    rst_n = 1;
    tick();
  endtask

  int fc;
  bit found;
  int s;

  initial begin
    idle();
    #2;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_count", 64'(cnt), 64'h0);
    #2;
    rst_n = 1;
    tick();

    // reset and rd=0
    drive(OP_IMM, 5, 0, 0);
    #1 chk("opimm_ready", 64'(ready), 64'h1);
    tick();
    chk("opimm_busy", 64'(busy), 64'h20);
    drive(OP, 0, 0, 0);
    #1 chk("x0_ready", 64'(ready), 64'h1);
    tick();
    chk("x0_busy", 64'(busy), 64'h20);
    idle();

    // RAW stall, writeback of x7 in cycle 4
    reset_dut();
    drive(LOAD, 7, 0, 0);
    tick();
    drive(OP, 8, 7, 0);
    fc = -1;
    wbrd = 7;
    for (int c = 1; c <= 10 && fc < 0; c++) begin
      wbv = (c == 4);
      #1;
      if (c == 1) chk("raw_stall", 64'(ready), 64'h0);
      if (ready) fc = c;
      tick();
    end
    idle();
    chk("raw_fire_cycle", 64'(fc), BYP ? 64'd4 : 64'd5);
    chk("raw_count", 64'(cnt), BYP ? 64'd3 : 64'd4);
    chk("raw_busy", 64'(busy), 64'h100);

    // WAW with simultaneous writeback of the same register
    reset_dut();
    drive(LUI, 9, 0, 0);
    tick();
    fc = -1;
    wbrd = 9;
    for (int c = 0; c <= 5 && fc < 0; c++) begin
      wbv = (c == 0);
      #1;
      if (ready) fc = c;
      tick();
    end
    idle();
    chk("waw_fire_cycle", 64'(fc), BYP ? 64'd0 : 64'd1);
    chk("waw_busy", 64'(busy), 64'h200);

    // SYSTEM waits for an empty scoreboard
    reset_dut();
    drive(LUI, 3, 0, 0);
    tick();
    drive(SYSTEM, 2, 1, 0);
    fc = -1;
    wbrd = 3;
    for (int c = 0; c <= 8 && fc < 0; c++) begin
      wbv = (c == 2);
      #1;
      if (c == 0) chk("sys_stall", 64'(ready), 64'h0);
      if (ready) fc = c;
      tick();
    end
    idle();
    chk("sys_fire_cycle", 64'(fc), 64'd3);
    chk("sys_busy", 64'(busy), 64'h4);

    // flush drops everything, including same-cycle issue and writeback
    reset_dut();
    drive(LUI, 1, 0, 0);
    tick();
    drive(LUI, 4, 0, 0);
    tick();
    drive(LUI, 31, 0, 0);
    tick();
    idle();
    chk("pre_flush_busy", 64'(busy), 64'h80000012);
    drive(LUI, 6, 0, 0);
    flush = 1; wbv = 1; wbrd = 1;
    #1 chk("flush_ready", 64'(ready), 64'h0);
    tick();
    idle();
    chk("flush_busy", 64'(busy), 64'h0);
    chk("flush_empty", 64'(empty), 64'h1);
    chk("flush_count", 64'(cnt), 64'h0);

    // saturation, then asynchronous reset mid-stall
    reset_dut();
    drive(LOAD, 7, 0, 0);
    tick();
    drive(OP, 8, 7, 0);
    repeat (20) tick();
    chk("sat_count", 64'(cnt), 64'd15);
    chk("sat_busy", 64'(busy), 64'h80);
    #2 rst_n = 0;
    #1;
    chk("arst_count", 64'(cnt), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_empty", 64'(empty), 64'h1);
    @(posedge clk);
    #1;
    rst_n = 1;
    idle();
    tick();

    // randomized traffic
    reset_dut();
    repeat (3000) begin
      iv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0)
        op = opcode_e'($urandom_range(0, 31));
      else
        op = ops[$urandom_range(0, 11)];
      rd  = reg_index_t'($urandom_range(0, 7));
      rs1 = reg_index_t'($urandom_range(0, 7));
      rs2 = reg_index_t'($urandom_range(0, 31));
      wbv = 0;
      wbrd = 0;
      if (m_busy != 0 && $urandom_range(0, 2) == 0) begin
        found = 0;
        s = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
          if (!found && m_busy[(s + k) % 32]) begin
            found = 1;
            wbrd = reg_index_t'((s + k) % 32);
          end
        end
        wbv = found;
      end
      flush = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
